// File: rtl/key_press_emulator.sv
// Emulated active-low mechanical key: press bounce, clean hold, release bounce.
// Bounce segment lengths come from a free-running 16-bit Galois LFSR.
module key_press_emulator #(
    parameter int          HOLD_W       = 20,
    parameter int          BOUNCE_EDGES = 6,
    parameter int          BOUNCE_W     = 8,
    parameter int          GAP_CYCLES   = 1000,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [HOLD_W-1:0] hold_len,
    input  logic              bounce_en,
    output logic              key_out,
    output logic              pressed,
    output logic              busy,
    output logic              done
);

    localparam int SW = BOUNCE_W + 1;
    localparam int EW = $clog2(BOUNCE_EDGES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [EW-1:0] LAST_EDGE = EW'(BOUNCE_EDGES - 1);
    localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        P_BNC,
        HOLD,
        R_BNC,
        GAP
    } state_t;

    state_t            state, state_n;
    logic [15:0]       lfsr, lfsr_n;
    logic [HOLD_W-1:0] hold_r, hold_r_n;
    logic              bnc_r, bnc_r_n;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_n;
    logic [SW-1:0]     seg_cnt, seg_cnt_n;
    logic [EW-1:0]     edge_cnt, edge_cnt_n;
    logic [GW-1:0]     gap_cnt, gap_cnt_n;
    logic              key_n, pressed_n, busy_n, done_n;

    logic [SW-1:0]     seg_load;
    logic [HOLD_W-1:0] hold_eff;

    assign seg_load = {1'b0, lfsr[BOUNCE_W-1:0]} + SW'(1);
    assign hold_eff = (hold_len == '0) ? HOLD_W'(1) : hold_len;
    assign lfsr_n   = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);

    // State, counters, LFSR and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            lfsr     <= LFSR_SEED;
            hold_r   <= '0;
            bnc_r    <= 1'b0;
            hold_cnt <= '0;
            seg_cnt  <= '0;
            edge_cnt <= '0;
            gap_cnt  <= '0;
            key_out  <= 1'b1;
            pressed  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            lfsr     <= lfsr_n;
            hold_r   <= hold_r_n;
            bnc_r    <= bnc_r_n;
            hold_cnt <= hold_cnt_n;
            seg_cnt  <= seg_cnt_n;
            edge_cnt <= edge_cnt_n;
            gap_cnt  <= gap_cnt_n;
            key_out  <= key_n;
            pressed  <= pressed_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

    // Next-state and next-output decode; each counter holds at its terminal
    always_comb begin
        state_n    = state;
        hold_r_n   = hold_r;
        bnc_r_n    = bnc_r;
        hold_cnt_n = hold_cnt;
        seg_cnt_n  = seg_cnt;
        edge_cnt_n = edge_cnt;
        gap_cnt_n  = gap_cnt;
        key_n      = key_out;
        pressed_n  = pressed;
        busy_n     = busy;
        done_n     = 1'b0;
        unique case (state)
            IDLE: begin
                key_n     = 1'b1;
                pressed_n = 1'b0;
                busy_n    = 1'b0;
                if (start) begin
                    hold_r_n  = hold_eff;
                    bnc_r_n   = bounce_en;
                    key_n     = 1'b0;
                    pressed_n = 1'b1;
                    busy_n    = 1'b1;
                    if (bounce_en) begin
                        state_n    = P_BNC;
                        seg_cnt_n  = seg_load;
                        edge_cnt_n = '0;
                    end else begin
                        state_n    = HOLD;
                        hold_cnt_n = hold_eff;
                    end
                end
            end
            P_BNC: begin
                if (seg_cnt <= SW'(1)) begin
                    key_n      = ~key_out;
                    edge_cnt_n = edge_cnt + EW'(1);
                    seg_cnt_n  = seg_load;
                    if (edge_cnt == LAST_EDGE) begin
                        state_n    = HOLD;
                        key_n      = 1'b0;
                        hold_cnt_n = hold_r;
                    end
                end else begin
                    seg_cnt_n = seg_cnt - SW'(1);
                end
            end
            HOLD: begin
                if (hold_cnt <= HOLD_W'(1)) begin
                    key_n     = 1'b1;
                    pressed_n = 1'b0;
                    if (bnc_r) begin
                        state_n    = R_BNC;
                        seg_cnt_n  = seg_load;
                        edge_cnt_n = '0;
                    end else begin
                        state_n   = GAP;
                        gap_cnt_n = GAP_LOAD;
                    end
                end else begin
                    hold_cnt_n = hold_cnt - HOLD_W'(1);
                end
            end
            R_BNC: begin
                if (seg_cnt <= SW'(1)) begin
                    key_n      = ~key_out;
                    edge_cnt_n = edge_cnt + EW'(1);
                    seg_cnt_n  = seg_load;
                    if (edge_cnt == LAST_EDGE) begin
                        state_n   = GAP;
                        key_n     = 1'b1;
                        gap_cnt_n = GAP_LOAD;
                    end
                end else begin
                    seg_cnt_n = seg_cnt - SW'(1);
                end
            end
            GAP: begin
                key_n = 1'b1;
                if (gap_cnt <= GW'(1)) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                end else begin
                    gap_cnt_n = gap_cnt - GW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                key_n   = 1'b1;
            end
        endcase
    end

endmodule

// File: doc/key_press_emulator.md
Name: key_press_emulator

Overview:
- Transmit-side counterpart of the key debouncer: generates a realistic active-low mechanical key waveform on command, with press bounce, clean hold and release bounce.
- Drives debouncer inputs in loopback self-test, and bench or demo stimulus for the tetris key path, with no physical button.
- Bounce segment lengths come from an internal LFSR, so repeated presses differ but stay reproducible from reset.

Parameters:
HOLD_W, 20, width of hold_len and the hold counter
BOUNCE_EDGES, 6, key_out toggles per bounce phase; must be even and >= 2
BOUNCE_W, 8, segment length = LFSR[BOUNCE_W-1:0] + 1 cycles (1..2^BOUNCE_W)
GAP_CYCLES, 1000, minimum clean-high cycles after release before done
LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
start  input  1  one-cycle press request; sampled only in IDLE
hold_len  input  HOLD_W  clean-low hold length in cycles; latched on accepted start; 0 treated as 1
bounce_en  input  1  latched on accepted start; 0 = no bounce phases
key_out  output  1  emulated key line, active-low (1 = released)
pressed  output  1  clean reference level for checkers: 1 from accept through the last HOLD cycle
busy  output  1  1 in every state except IDLE
done  output  1  one-cycle pulse on return to IDLE

Behaviour:
- Reset (rst high at a clk edge): state=IDLE, key_out=1, pressed=0, busy=0, done=0, LFSR=LFSR_SEED, all counters 0. Reset mid-operation aborts immediately; key_out is 1 the next cycle.
- All outputs are registered.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1. Advances every cycle when not in reset.
- States: IDLE, P_BNC, HOLD, R_BNC, GAP.
- IDLE: start=1 latches hold_len and bounce_en and sets pressed=1, busy=1.
  - Next state is P_BNC if bounce_en=1, else HOLD.
  - key_out is 0 in the cycle after start is sampled (1-cycle latency).
  - start while busy=1 is ignored; there is no queueing.
- P_BNC:
  - On entry, key_out=0 and the segment counter loads LFSR[BOUNCE_W-1:0]+1.
  - On segment expiry, key_out toggles, edge_cnt increments and the segment counter reloads from the current LFSR.
  - After BOUNCE_EDGES toggles key_out is 0 (even count) and the state goes to HOLD.
- HOLD: key_out=0 for exactly max(hold_len,1) cycles. In the last HOLD cycle pressed drops to 0 on the next edge.
- R_BNC: on entry key_out=1. Same segment and toggle rules as P_BNC; after BOUNCE_EDGES toggles key_out=1, go to GAP. Skipped when bounce_en=0.
- GAP: key_out=1 for GAP_CYCLES cycles, then IDLE with done=1 and busy=0 in the same cycle.
  - A start in the done cycle is accepted (state is IDLE).
- Counter widths: hold counter HOLD_W bits; segment counter BOUNCE_W+1 bits; edge_cnt sized for BOUNCE_EDGES; GAP counter sized for GAP_CYCLES. No counter wraps; each counter stops at its terminal count.
- hold_len and bounce_en changes while busy have no effect.
- Invariant: key_out=1 whenever state is IDLE or GAP.

Test Plan:
- Reset then idle 100 cycles -> key_out=1, busy=0, done=0, pressed=0 throughout.
- bounce_en=0, hold_len=10, start at cycle T:
  - key_out=0 for cycles T+1..T+10 exactly and 1 from T+11.
  - done pulses once at T+11+GAP_CYCLES.
  - busy=1 from T+1 to that pulse.
- bounce_en=1, hold_len=50:
  - Count key_out edges: 6 during press and 6 during release, each segment 1..256 cycles.
  - The 50-cycle low run is unbroken.
  - After two resets the edge timing is identical (seed reproducibility).
- start re-asserted every cycle while busy -> exactly one press; the next press begins the cycle after the done cycle if start is held.
- rst asserted mid-HOLD -> key_out=1, busy=0, pressed=0 next cycle; no done pulse.
- Loopback into the debouncer:
  - bounce_en=1, hold_len=300000 -> debouncer emits exactly one 1-cycle key pulse per press.
  - hold_len=200000 -> zero pulses.
